// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types for the ID/EX operand stage: forwarding select codes and the
// decode control bundle carried into EX.
package id_ex_pkg;

    localparam int REG_ZERO     = 0;
    localparam int ALU_OP_W_PKG = 4;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_MEM,
        FWD_WB
    } fwd_sel_e;

    typedef struct packed {
        logic                    reg_we;
        logic                    mem_read;
        logic                    mem_write;
        logic [ALU_OP_W_PKG-1:0] alu_op;
    } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Pipeline-side bundle for the ID/EX operand stage: decode inputs, register
// file read data, MEM/WB write-back triplets and the EX-side outputs.
interface id_ex_operand_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N_WORDS    = 32,
    parameter int ALU_OP_W   = 4
);
    localparam int AW = $clog2(N_WORDS);

    logic                  id_valid;
    logic [AW-1:0]         id_rs;
    logic [AW-1:0]         id_rt;
    logic [AW-1:0]         id_rd;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic [DATA_WIDTH-1:0] qs;
    logic [DATA_WIDTH-1:0] qt;
    logic [DATA_WIDTH-1:0] id_imm;
    logic                  id_use_imm;
    logic                  id_reg_we;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic [ALU_OP_W-1:0]   id_alu_op;
    logic                  flush;
    logic                  mem_reg_we;
    logic [AW-1:0]         mem_rd;
    logic [DATA_WIDTH-1:0] mem_result;
    logic                  wb_reg_we;
    logic [AW-1:0]         wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;

    logic                  stall_id;
    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_a;
    logic [DATA_WIDTH-1:0] ex_b;
    logic [DATA_WIDTH-1:0] ex_store_data;
    logic [AW-1:0]         ex_rd;
    logic                  ex_reg_we;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic [ALU_OP_W-1:0]   ex_alu_op;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_rs_used, id_rt_used,
        output qs, qt, id_imm, id_use_imm,
        output id_reg_we, id_mem_read, id_mem_write, id_alu_op,
        output flush, mem_reg_we, mem_rd, mem_result,
        output wb_reg_we, wb_rd, wb_data,
        input  stall_id, ex_valid, ex_a, ex_b, ex_store_data, ex_rd,
        input  ex_reg_we, ex_mem_read, ex_mem_write, ex_alu_op
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_rs_used, id_rt_used,
        input  qs, qt, id_imm, id_use_imm,
        input  id_reg_we, id_mem_read, id_mem_write, id_alu_op,
        input  flush, mem_reg_we, mem_rd, mem_result,
        input  wb_reg_we, wb_rd, wb_data,
        output stall_id, ex_valid, ex_a, ex_b, ex_store_data, ex_rd,
        output ex_reg_we, ex_mem_read, ex_mem_write, ex_alu_op
    );

endinterface

// File: rtl/id_ex_operand_stage_fwd.sv
// EX-side operand forwarding for one source: MEM beats WB beats the captured
// value, and register 0 is never forwarded.
module operand_fwd_mux
    import id_ex_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 5
) (
    input  logic [AW-1:0]         i_src,
    input  logic [DATA_WIDTH-1:0] i_val,
    input  logic                  i_mem_we,
    input  logic [AW-1:0]         i_mem_rd,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_wb_we,
    input  logic [AW-1:0]         i_wb_rd,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output fwd_sel_e              o_sel
);

    logic w_src_nz;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_src_nz  = (i_src != AW'(REG_ZERO));
    assign w_mem_hit = i_mem_we && (i_mem_rd == i_src) && w_src_nz;
    assign w_wb_hit  = i_wb_we  && (i_wb_rd  == i_src) && w_src_nz;

    always_comb begin
        o_sel  = FWD_REG;
        o_data = i_val;
        if (w_mem_hit) begin
            o_sel  = FWD_MEM;
            o_data = i_mem_data;
        end else if (w_wb_hit) begin
            o_sel  = FWD_WB;
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register behind the register file: same-cycle WB bypass on
// capture, load-use stall with bubble insertion, and MEM/WB forwarding in EX.
module id_ex_operand_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_WORDS    = 32,
    parameter int ALU_OP_W   = ALU_OP_W_PKG
) (
    input  logic                clk,
    input  logic                rst_n,
    id_ex_operand_stage_if.slave bus
);

    localparam int AW = $clog2(N_WORDS);

    logic [DATA_WIDTH-1:0] w_rs_cap;
    logic [DATA_WIDTH-1:0] w_rt_cap;
    logic                  w_hz;
    logic [ALU_OP_W-1:0]   w_alu_op_in;
    id_ex_ctrl_t           w_ctrl_in;
    logic [DATA_WIDTH-1:0] w_fwd_a;
    logic [DATA_WIDTH-1:0] w_fwd_b;
    fwd_sel_e              w_sel_a;
    fwd_sel_e              w_sel_b;

    logic                  r_valid;
    id_ex_ctrl_t           r_ctrl;
    logic [AW-1:0]         r_rd;
    logic [AW-1:0]         r_rs;
    logic [AW-1:0]         r_rt;
    logic [DATA_WIDTH-1:0] r_rs_val;
    logic [DATA_WIDTH-1:0] r_rt_val;
    logic [DATA_WIDTH-1:0] r_imm;
    logic                  r_use_imm;

    // The register file writes on the edge, so a read of the register being
    // written this cycle still returns the old value; take wb_data instead.
    assign w_rs_cap = (bus.wb_reg_we && (bus.wb_rd == bus.id_rs) && (bus.id_rs != AW'(REG_ZERO)))
                      ? bus.wb_data : bus.qs;
    assign w_rt_cap = (bus.wb_reg_we && (bus.wb_rd == bus.id_rt) && (bus.id_rt != AW'(REG_ZERO)))
                      ? bus.wb_data : bus.qt;

    assign w_hz = r_valid && r_ctrl.mem_read && (r_rd != AW'(REG_ZERO)) && bus.id_valid &&
                  ((bus.id_rs_used && (bus.id_rs == r_rd)) ||
                   (bus.id_rt_used && (bus.id_rt == r_rd)));

    assign bus.stall_id = w_hz && !bus.flush;

    assign w_alu_op_in = bus.id_alu_op;

    always_comb begin
        w_ctrl_in = '0;
        if (bus.id_valid) begin
            w_ctrl_in.reg_we    = bus.id_reg_we;
            w_ctrl_in.mem_read  = bus.id_mem_read;
            w_ctrl_in.mem_write = bus.id_mem_write;
            w_ctrl_in.alu_op    = w_alu_op_in;
        end
    end

    // Flush and load-use both load a bubble; flush only matters for stall_id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_rd      <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rs_val  <= '0;
            r_rt_val  <= '0;
            r_imm     <= '0;
            r_use_imm <= 1'b0;
        end else if (bus.flush || w_hz) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_rd      <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rs_val  <= '0;
            r_rt_val  <= '0;
            r_imm     <= '0;
            r_use_imm <= 1'b0;
        end else begin
            r_valid   <= bus.id_valid;
            r_ctrl    <= w_ctrl_in;
            r_rd      <= bus.id_rd;
            r_rs      <= bus.id_rs;
            r_rt      <= bus.id_rt;
            r_rs_val  <= w_rs_cap;
            r_rt_val  <= w_rt_cap;
            r_imm     <= bus.id_imm;
            r_use_imm <= bus.id_use_imm;
        end
    end

    operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_fwd_rs (
        .i_src      (r_rs),
        .i_val      (r_rs_val),
        .i_mem_we   (bus.mem_reg_we),
        .i_mem_rd   (bus.mem_rd),
        .i_mem_data (bus.mem_result),
        .i_wb_we    (bus.wb_reg_we),
        .i_wb_rd    (bus.wb_rd),
        .i_wb_data  (bus.wb_data),
        .o_data     (w_fwd_a),
        .o_sel      (w_sel_a)
    );

    operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_fwd_rt (
        .i_src      (r_rt),
        .i_val      (r_rt_val),
        .i_mem_we   (bus.mem_reg_we),
        .i_mem_rd   (bus.mem_rd),
        .i_mem_data (bus.mem_result),
        .i_wb_we    (bus.wb_reg_we),
        .i_wb_rd    (bus.wb_rd),
        .i_wb_data  (bus.wb_data),
        .o_data     (w_fwd_b),
        .o_sel      (w_sel_b)
    );

    // A forward selected for r0 would mean the zero guard has been lost.
    always_comb begin
        assert (!((r_rs == AW'(REG_ZERO)) && (w_sel_a != FWD_REG)));
        assert (!((r_rt == AW'(REG_ZERO)) && (w_sel_b != FWD_REG)));
    end

    assign bus.ex_valid      = r_valid;
    assign bus.ex_a          = w_fwd_a;
    assign bus.ex_b          = r_use_imm ? r_imm : w_fwd_b;
    assign bus.ex_store_data = w_fwd_b;
    assign bus.ex_rd         = r_rd;
    assign bus.ex_reg_we     = r_ctrl.reg_we;
    assign bus.ex_mem_read   = r_ctrl.mem_read;
    assign bus.ex_mem_write  = r_ctrl.mem_write;
    assign bus.ex_alu_op     = r_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: table of single-instruction vectors through a
// scoreboard queue, then hand sequences for reset, load-use and flush.
module tb_id_ex_operand_stage;
    import id_ex_pkg::*;

    localparam int DW  = 32;
    localparam int NW  = 32;
    localparam int AOW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.DATA_WIDTH(DW), .N_WORDS(NW), .ALU_OP_W(AOW)) bus ();

    id_ex_operand_stage #(.DATA_WIDTH(DW), .N_WORDS(NW), .ALU_OP_W(AOW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic        rs_used, rt_used;
        logic [31:0] qs, qt, imm;
        logic        use_imm, reg_we, mem_read, mem_write;
        logic [3:0]  alu;
        logic        cwb_we;
        logic [4:0]  cwb_rd;
        logic [31:0] cwb_data;
        logic        mem_we;
        logic [4:0]  mem_rd;
        logic [31:0] mem_res;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] exp_a, exp_b, exp_sd;
    } vec_t;

    typedef struct {
        logic        valid, reg_we, mem_read, mem_write;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [31:0] a, b, sd;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl[10];
    exp_t sb[$];

    function automatic vec_t id_vec(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [31:0] qs, input logic [31:0] qt);
        vec_t v;
        v = '{default: '0};
        v.valid = valid; v.rs = rs; v.rt = rt; v.qs = qs; v.qt = qt;
        v.rd = 5'd15; v.rs_used = 1'b1; v.rt_used = 1'b1;
        v.reg_we = 1'b1; v.alu = 4'h3;
        return v;
    endfunction

    function automatic exp_t model(input vec_t v);
        exp_t e;
        e.valid     = v.valid;
        e.reg_we    = v.valid & v.reg_we;
        e.mem_read  = v.valid & v.mem_read;
        e.mem_write = v.valid & v.mem_write;
        e.alu       = v.valid ? v.alu : 4'h0;
        e.rd        = v.rd;
        e.a = v.exp_a; e.b = v.exp_b; e.sd = v.exp_sd;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_id(input vec_t v);
        bus.id_valid = v.valid;     bus.id_rs = v.rs;          bus.id_rt = v.rt;
        bus.id_rd = v.rd;           bus.id_rs_used = v.rs_used; bus.id_rt_used = v.rt_used;
        bus.qs = v.qs;              bus.qt = v.qt;             bus.id_imm = v.imm;
        bus.id_use_imm = v.use_imm; bus.id_reg_we = v.reg_we;  bus.id_mem_read = v.mem_read;
        bus.id_mem_write = v.mem_write; bus.id_alu_op = v.alu;
        bus.flush = 1'b0;
        bus.mem_reg_we = 1'b0; bus.mem_rd = '0; bus.mem_result = '0;
        bus.wb_reg_we = v.cwb_we; bus.wb_rd = v.cwb_rd; bus.wb_data = v.cwb_data;
    endtask

    task automatic drive_ex(input vec_t v);
        bus.mem_reg_we = v.mem_we; bus.mem_rd = v.mem_rd; bus.mem_result = v.mem_res;
        bus.wb_reg_we  = v.wb_we;  bus.wb_rd  = v.wb_rd;  bus.wb_data    = v.wb_data;
    endtask

    task automatic check_ex(input string tag, input exp_t e);
        check({tag, ".ex_valid"},     bus.ex_valid,      e.valid);
        check({tag, ".ex_reg_we"},    bus.ex_reg_we,     e.reg_we);
        check({tag, ".ex_mem_read"},  bus.ex_mem_read,   e.mem_read);
        check({tag, ".ex_mem_write"}, bus.ex_mem_write,  e.mem_write);
        check({tag, ".ex_alu_op"},    bus.ex_alu_op,     e.alu);
        check({tag, ".ex_rd"},        bus.ex_rd,         e.rd);
        check({tag, ".ex_a"},         bus.ex_a,          e.a);
        check({tag, ".ex_b"},         bus.ex_b,          e.b);
        check({tag, ".ex_store_data"}, bus.ex_store_data, e.sd);
    endtask

    initial begin
        vec_t v, ld, use_v;
        exp_t e;

        // 0: plain capture, no forwarding
        v = id_vec(1, 5'd3, 5'd4, 32'h3, 32'h4);
        v.exp_a = 32'h3; v.exp_b = 32'h4; v.exp_sd = 32'h4; tbl[0] = v;
        // 1: MEM forward on rs
        v = id_vec(1, 5'd5, 5'd6, 32'h55, 32'h66);
        v.mem_we = 1; v.mem_rd = 5'd5; v.mem_res = 32'hAAAA;
        v.exp_a = 32'hAAAA; v.exp_b = 32'h66; v.exp_sd = 32'h66; tbl[1] = v;
        // 2: MEM and WB both hit r5, MEM wins on both operands
        v = id_vec(1, 5'd5, 5'd5, 32'h55, 32'h55);
        v.mem_we = 1; v.mem_rd = 5'd5; v.mem_res = 32'hAAAA;
        v.wb_we = 1;  v.wb_rd = 5'd5;  v.wb_data = 32'hBBBB;
        v.exp_a = 32'hAAAA; v.exp_b = 32'hAAAA; v.exp_sd = 32'hAAAA; tbl[2] = v;
        // 3: WB forward on rt
        v = id_vec(1, 5'd8, 5'd9, 32'h88, 32'h99);
        v.wb_we = 1; v.wb_rd = 5'd9; v.wb_data = 32'hBBBB;
        v.exp_a = 32'h88; v.exp_b = 32'hBBBB; v.exp_sd = 32'hBBBB; tbl[3] = v;
        // 4: same-cycle WB bypass at capture for rs
        v = id_vec(1, 5'd7, 5'd2, 32'h7, 32'h22);
        v.cwb_we = 1; v.cwb_rd = 5'd7; v.cwb_data = 32'h1234;
        v.exp_a = 32'h1234; v.exp_b = 32'h22; v.exp_sd = 32'h22; tbl[4] = v;
        // 5: r0 never bypassed or forwarded
        v = id_vec(1, 5'd0, 5'd0, 32'h0, 32'h0);
        v.cwb_we = 1; v.cwb_rd = 5'd0; v.cwb_data = 32'hDDDD;
        v.mem_we = 1; v.mem_rd = 5'd0; v.mem_res = 32'hFFFF;
        v.wb_we = 1;  v.wb_rd = 5'd0;  v.wb_data = 32'hEEEE;
        v.exp_a = 32'h0; v.exp_b = 32'h0; v.exp_sd = 32'h0; tbl[5] = v;
        // 6: immediate B, store data still forwarded from MEM
        v = id_vec(1, 5'd1, 5'd4, 32'h11, 32'h44);
        v.use_imm = 1; v.imm = 32'hFFFF_FFF0;
        v.mem_we = 1; v.mem_rd = 5'd4; v.mem_res = 32'h4444;
        v.exp_a = 32'h11; v.exp_b = 32'hFFFF_FFF0; v.exp_sd = 32'h4444; tbl[6] = v;
        // 7: invalid slot, controls gated to 0
        v = id_vec(0, 5'd2, 5'd3, 32'h20, 32'h30);
        v.rd = 5'd0; v.mem_write = 1; v.alu = 4'h5;
        v.exp_a = 32'h20; v.exp_b = 32'h30; v.exp_sd = 32'h30; tbl[7] = v;
        // 8: store with WB forward on rs
        v = id_vec(1, 5'd10, 5'd11, 32'h100, 32'h200);
        v.rd = 5'd0; v.reg_we = 0; v.mem_write = 1; v.alu = 4'hA;
        v.wb_we = 1; v.wb_rd = 5'd10; v.wb_data = 32'h1010;
        v.exp_a = 32'h1010; v.exp_b = 32'h200; v.exp_sd = 32'h200; tbl[8] = v;
        // 9: rt bypassed at capture, then overridden by MEM in EX
        v = id_vec(1, 5'd13, 5'd12, 32'h13, 32'h12);
        v.cwb_we = 1; v.cwb_rd = 5'd12; v.cwb_data = 32'hC0C0;
        v.mem_we = 1; v.mem_rd = 5'd12; v.mem_res = 32'hDDDD;
        v.exp_a = 32'h13; v.exp_b = 32'hDDDD; v.exp_sd = 32'hDDDD; tbl[9] = v;

        drive_id(id_vec(0, 5'd0, 5'd0, 32'h0, 32'h0));
        #2;
        check("reset.ex_valid", bus.ex_valid, 1'b0);
        check("reset.ex_a", bus.ex_a, 32'h0);
        check("reset.stall_id", bus.stall_id, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_id(tbl[i]);
            sb.push_back(model(tbl[i]));
            #1 check($sformatf("vec%0d.stall_id", i), bus.stall_id, 1'b0);
            @(posedge clk);
            #1 drive_ex(tbl[i]);
            #1 e = sb.pop_front();
            check_ex($sformatf("vec%0d", i), e);
        end

        // Reset asserted while a load-use stall is pending
        ld = id_vec(1, 5'd1, 5'd2, 32'h11, 32'h22);
        ld.rd = 5'd4; ld.mem_read = 1; ld.rt_used = 0;
        use_v = id_vec(1, 5'd4, 5'd0, 32'h0BAD, 32'h0);
        use_v.rd = 5'd8; use_v.rt_used = 0;
        @(negedge clk); drive_id(ld);
        @(posedge clk); #1 drive_id(use_v);
        #1 check("rst_mid.stall_before", bus.stall_id, 1'b1);
        check("rst_mid.valid_before", bus.ex_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.stall_id", bus.stall_id, 1'b0);
        check("rst_mid.ex_valid", bus.ex_valid, 1'b0);
        check("rst_mid.ex_mem_read", bus.ex_mem_read, 1'b0);
        check("rst_mid.ex_rd", bus.ex_rd, 5'd0);
        check("rst_mid.ex_a", bus.ex_a, 32'h0);
        check("rst_mid.ex_b", bus.ex_b, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_id(id_vec(1, 5'd3, 5'd0, 32'h3, 32'h0));
        @(posedge clk); #2;
        check("rst_rel.ex_a", bus.ex_a, 32'h3);
        check("rst_rel.ex_valid", bus.ex_valid, 1'b1);

        // Load-use: one stall, bubble, then operand via WB forwarding
        @(negedge clk); drive_id(ld);
        @(posedge clk); #1 drive_id(use_v);
        #1 check("lu.stall", bus.stall_id, 1'b1);
        @(posedge clk); #2;
        check("lu.bubble_valid", bus.ex_valid, 1'b0);
        check("lu.bubble_reg_we", bus.ex_reg_we, 1'b0);
        check("lu.stall_cleared", bus.stall_id, 1'b0);
        @(posedge clk); #1;
        bus.wb_reg_we = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'hCAFE;
        #1;
        check("lu.ex_valid", bus.ex_valid, 1'b1);
        check("lu.ex_rd", bus.ex_rd, 5'd8);
        check("lu.ex_a", bus.ex_a, 32'hCAFE);

        // Back-to-back loads to r6, each dependent stalls one cycle
        v = id_vec(1, 5'd1, 5'd0, 32'h1, 32'h0);
        v.rd = 5'd6; v.mem_read = 1; v.rt_used = 0;
        @(negedge clk); drive_id(v);
        v.rs = 5'd6;
        @(posedge clk); #1 drive_id(v);
        #1 check("b2b.stall1", bus.stall_id, 1'b1);
        @(posedge clk); #2;
        check("b2b.bubble1", bus.ex_valid, 1'b0);
        check("b2b.nostall1", bus.stall_id, 1'b0);
        @(posedge clk); #1;
        check("b2b.ld2_mem_read", bus.ex_mem_read, 1'b1);
        v = id_vec(1, 5'd0, 5'd6, 32'h0, 32'h66);
        v.rs_used = 0; v.rd = 5'd9;
        drive_id(v);
        #1 check("b2b.stall2", bus.stall_id, 1'b1);
        @(posedge clk); #2;
        check("b2b.bubble2", bus.ex_valid, 1'b0);
        check("b2b.nostall2", bus.stall_id, 1'b0);
        @(posedge clk); #2;
        check("b2b.add_valid", bus.ex_valid, 1'b1);
        check("b2b.add_rd", bus.ex_rd, 5'd9);

        // Load to r0 followed by a use of r0: no stall
        v = id_vec(1, 5'd1, 5'd0, 32'h1, 32'h0);
        v.rd = 5'd0; v.mem_read = 1;
        @(negedge clk); drive_id(v);
        @(posedge clk); #1 drive_id(id_vec(1, 5'd0, 5'd0, 32'h0, 32'h0));
        #1 check("r0ld.ex_mem_read", bus.ex_mem_read, 1'b1);
        check("r0ld.stall", bus.stall_id, 1'b0);

        // Flush with a load-use hazard present: flush wins
        @(negedge clk); drive_id(ld);
        @(posedge clk); #1 drive_id(use_v);
        bus.flush = 1'b1;
        #1 check("flush.stall", bus.stall_id, 1'b0);
        @(posedge clk); #1 bus.flush = 1'b0;
        #1 check("flush.ex_valid", bus.ex_valid, 1'b0);
        check("flush.ex_reg_we", bus.ex_reg_we, 1'b0);
        check("flush.ex_rd", bus.ex_rd, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register that sits directly downstream of the register file.
- Captures the register file's combinational qs/qt outputs, together with decode control, at each clock edge.
- Applies EX-side operand forwarding from the MEM and WB stages.
- Detects load-use hazards and stalls decode for one cycle while inserting a bubble.
- Also provides the same-cycle WB→ID bypass, because the register file updates on the edge and its reads return the pre-write value during the write cycle.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- N_WORDS, 32, register count; address width AW = $clog2(N_WORDS).
- ALU_OP_W, 4, ALU opcode width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs  in  AW  source register A address (also drives the register file's rs).
- id_rt  in  AW  source register B address.
- id_rd  in  AW  destination address.
- id_rs_used  in  1  instruction reads rs.
- id_rt_used  in  1  instruction reads rt.
- qs  in  DATA_WIDTH  register file read port S.
- qt  in  DATA_WIDTH  register file read port T.
- id_imm  in  DATA_WIDTH  sign-extended immediate.
- id_use_imm  in  1  B operand is the immediate.
- id_reg_we  in  1  decode control: register write enable.
- id_mem_read  in  1  decode control: load.
- id_mem_write  in  1  decode control: store.
- id_alu_op  in  ALU_OP_W  decode control: ALU opcode.
- flush  in  1  kill the instruction entering EX (branch taken).
- mem_reg_we  in  1  MEM-stage write enable.
- mem_rd  in  AW  MEM-stage destination.
- mem_result  in  DATA_WIDTH  MEM-stage ALU result.
- wb_reg_we  in  1  WB write enable; same signals as register file we/rd/d.
- wb_rd  in  AW  WB destination.
- wb_data  in  DATA_WIDTH  WB write data.
- stall_id  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  EX slot valid.
- ex_a  out  DATA_WIDTH  forwarded operand A.
- ex_b  out  DATA_WIDTH  forwarded operand B, or the immediate.
- ex_store_data  out  DATA_WIDTH  forwarded rt value for stores.
- ex_rd  out  AW  EX destination.
- ex_reg_we  out  1  EX register write enable.
- ex_mem_read  out  1  EX load flag.
- ex_mem_write  out  1  EX store flag.
- ex_alu_op  out  ALU_OP_W  EX ALU opcode.

Behaviour:
- Reset: asynchronous on rst_n low. All registers clear: ex_valid, controls, ex_rd and the captured operand/immediate registers go to 0. ex_a, ex_b and ex_store_data then read 0 unless a MEM/WB forward hits. stall_id is 0 in reset. Reset mid-stall drops the bubble and the hazard.
- Latency: one cycle from ID capture to EX outputs. Forwarding muxes on ex_a, ex_b and ex_store_data are combinational from the registers and the MEM/WB inputs.
- Capture bypass: rs_cap = (wb_reg_we && wb_rd==id_rs && id_rs!=0) ? wb_data : qs. The same rule applies to rt_cap against qt.
- Register 0: never forwarded or bypassed, whether as source or destination. Address 0 always reads the captured value.
- Load-use hazard: hz = ex_valid && ex_mem_read && ex_rd!=0 && id_valid, and ((id_rs_used && id_rs==ex_rd) || (id_rt_used && id_rt==ex_rd)).
- stall_id = hz && !flush. Combinational, from registered EX state and ID inputs only.
- Next-state priority is flush, then hz, then normal:
  - Flush: load a bubble.
  - hz: load a bubble. Upstream holds, so the same instruction re-presents next cycle with the hazard cleared.
  - Normal: capture ID; ex_valid <= id_valid.
- Bubble: ex_valid, ex_reg_we, ex_mem_read, ex_mem_write = 0; ex_rd = 0; ex_alu_op = 0; captured data = 0.
- Control gating: if id_valid=0, the control bits are captured as 0 regardless of their inputs.
- EX forwarding for A, from captured source s_q and value v_q:
  - mem_reg_we && mem_rd==s_q && s_q!=0 → mem_result.
  - else wb_reg_we && wb_rd==s_q && s_q!=0 → wb_data.
  - else v_q.
  - MEM has priority over WB because it is the younger instruction.
- Same forwarding rule for rt: feeds ex_store_data, and feeds ex_b when use_imm_q=0. When use_imm_q=1, ex_b = imm_q.
- No forwarding from MEM for loads is needed; the hz stall guarantees this.
- Flush and hz in the same cycle: flush wins, stall_id=0.
- Back-to-back loads to the same rd: each dependent instruction stalls exactly one cycle.

Decomposition:
- Package id_ex_pkg holds:
  - typedef enum fwd_sel_e {FWD_REG, FWD_MEM, FWD_WB};
  - localparam REG_ZERO = 0;
  - a packed struct id_ex_ctrl_t {reg_we, mem_read, mem_write, alu_op}.
- One sub-module, operand_fwd_mux: inputs are the source address, captured value and MEM/WB write triplets; outputs are the data and fwd_sel_e. It is instantiated twice (rs, rt).

Test Plan:
- Reset: rst_n low mid-stream with ex_valid=1 → all outputs 0 immediately, stall_id=0; after release, a capture of id_valid=1, rs=3, qs=0x3 gives ex_a=0x3 next cycle.
- MEM forward: ADD r5 in MEM (mem_rd=5, mem_result=0xAAAA), EX source rs_q=5 → ex_a=0xAAAA. With WB also writing r5=0xBBBB → still 0xAAAA (MEM priority).
- Same-cycle WB bypass: wb_reg_we=1, wb_rd=7, wb_data=0x1234, id_rs=7, qs=0x7 (stale) → next cycle ex_a=0x1234 with no MEM/WB hit.
- Load-use: EX holds LW r4, ID uses rs=4 → stall_id=1 one cycle, next ex_valid=0; following cycle the instruction enters EX and gets wb_data via forwarding.
- r0 guard: mem_reg_we=1, mem_rd=0, mem_result=0xFFFF, rs_q=0 → ex_a=captured 0. An LW r0 followed by a use of r0 → no stall.
- Flush+hazard: flush=1 while hz true → stall_id=0, ex_valid=0 next cycle, ex_reg_we=0.
